seq_div: RTL and testbench
==========================

SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning operand/result width (only 32 and 64 are legal).
REQ-002 SHALL have parameter EU_CTL_LEN, default 4, meaning control field width (must be >= 3).
REQ-003 SHALL have port clk_i  in  1  clock; every register samples on the rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port flush_i  in  1  synchronous pipeline flush.
REQ-006 SHALL have ports valid_i in 1 and ready_o out 1, forming the input handshake.
REQ-007 SHALL have ports valid_o out 1 and ready_i in 1, forming the output handshake.
REQ-008 SHALL have port ctl_i  in  EU_CTL_LEN  op select: bit0 = unsigned, bit1 = remainder, bit2 = word (32-bit); other bits ignored.
REQ-009 SHALL have ports rs1_value_i and rs2_value_i  in  WIDTH  dividend and divisor.
REQ-010 SHALL have ports rob_idx_i in and rob_idx_o out, both of type expipe_pkg::rob_idx_t, carrying the ROB tag.
REQ-011 SHALL have port result_o  out  WIDTH  quotient or remainder.
REQ-012 SHALL have ports except_raised_o out 1 and except_code_o out expipe_pkg::except_code_t.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-014 SHALL drive ready_o=1 only in IDLE; valid_o=1 only in DONE.
REQ-015 SHALL, in IDLE with valid_i=1, capture operands, ctl and rob_idx, and go to BUSY (or to DONE via the fast path, see REQ-027).
REQ-016 SHALL use a radix-2 restoring or non-restoring algorithm, one quotient bit per cycle; N = 32 iterations when bit2=1 or WIDTH=32, otherwise N = WIDTH.
REQ-017 SHALL hold BUSY for exactly N cycles, then enter DONE; accept at edge k gives valid_o=1 in cycle k+N+1.
REQ-018 SHALL hold result_o and rob_idx_o stable in DONE until ready_i=1; on the handshake, go to IDLE (no same-cycle re-accept).
REQ-019 SHALL, for signed ops, divide magnitudes; quotient negated iff the operand signs differ; remainder takes the dividend's sign.
REQ-020 SHALL, when the divisor is 0, return quotient all-ones and remainder = dividend.
REQ-021 SHALL, for signed most-negative / -1, return quotient = dividend and remainder = 0.
REQ-022 SHALL, for word ops, use operand bits [31:0] only, sign-extend the 32-bit result to WIDTH, and ignore bit2 when WIDTH=32.
REQ-023 SHALL tie except_raised_o=0 and except_code_o=0 (divide raises no exception).
REQ-024 SHALL, on flush_i=1 in any state, return to IDLE next cycle with valid_o=0 and drop any in-flight operation; flush has priority over valid_i and ready_i.

Reset
REQ-025 SHALL, while rst_ni=0, force state IDLE and clear all datapath/tag registers.
REQ-026 SHALL hold outputs at reset: ready_o=1, valid_o=0, result_o=0, rob_idx_o=0, except_raised_o=0, except_code_o=0; reset mid-BUSY aborts the operation.

Configuration
REQ-027 SHALL, with macro SEQ_DIV_FAST_PATH_EN defined, complete divisor-zero and signed-overflow cases IDLE->DONE directly (valid_o in cycle k+1) with the REQ-020/021 results.
REQ-028 SHALL, without SEQ_DIV_FAST_PATH_EN, send those cases through BUSY for N cycles, giving bit-identical results with the latency of REQ-017.

Verification
REQ-029 SHALL cover: DIV WIDTH=64, rs1=-7, rs2=2 -> result -3, valid_o in cycle k+65; REM of the same operands -> result -1.
REQ-030 SHALL cover: DIVUW rs1=0xFFFF_FFFF_8000_0000, rs2=2 -> result 0x0000_0000_4000_0000 after 33 cycles.
REQ-031 SHALL cover: DIV rs2=0 -> 0xFFFF_FFFF_FFFF_FFFF; REMU rs2=0, rs1=5 -> 5; latency 1 with SEQ_DIV_FAST_PATH_EN, 65 without.
REQ-032 SHALL cover: DIV rs1=0x8000_0000_0000_0000, rs2=-1 -> rs1; REM -> 0.
REQ-033 SHALL cover: ready_i=0 for 10 cycles in DONE -> result_o and rob_idx_o stable; flush_i at BUSY cycle 20 -> IDLE next cycle, no valid_o.
REQ-034 SHALL cover: rst_ni low mid-BUSY -> all outputs at REQ-026 values; after release, a new operation completes correctly.

Source files
------------

// File: rtl/seq_div.sv
// Sequential radix-2 restoring divider with valid/ready handshakes.
// Optional macro SEQ_DIV_FAST_PATH_EN: divisor-zero and signed-overflow
// cases skip BUSY and complete IDLE->DONE directly.

package expipe_pkg;
  typedef logic [5:0] rob_idx_t;
  typedef logic [4:0] except_code_t;
endpackage

// state | meaning
// IDLE  | ready for a new operation (ready_o=1)
// BUSY  | iterating, one quotient bit per cycle
// DONE  | result valid, waiting for ready_i
module seq_div #(
  parameter int WIDTH      = 64,
  parameter int EU_CTL_LEN = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  input  logic [EU_CTL_LEN-1:0]    ctl_i,
  input  logic [WIDTH-1:0]         rs1_value_i,
  input  logic [WIDTH-1:0]         rs2_value_i,
  input  expipe_pkg::rob_idx_t     rob_idx_i,
  output expipe_pkg::rob_idx_t     rob_idx_o,
  output logic [WIDTH-1:0]         result_o,
  output logic                     except_raised_o,
  output expipe_pkg::except_code_t except_code_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     quo, rem, divisor;
  logic [CW-1:0]        cnt;
  logic                 neg_q, neg_r, is_rem, word;
  expipe_pkg::rob_idx_t rob_idx;

  // operand decode at the input side
  logic             word_in, is_signed_in, a_neg, b_neg, div0_in, fast_in, accept;
  logic [WIDTH-1:0] a_ext, b_ext, a_mag, b_mag;
  logic [CW-1:0]    cnt_load;
  logic             ctl_unused;

  assign ctl_unused   = ^ctl_i;
  assign word_in      = ctl_i[2] || (WIDTH == 32);
  assign is_signed_in = !ctl_i[0];
  assign a_ext = !word_in ? rs1_value_i :
                 is_signed_in ? WIDTH'(signed'(rs1_value_i[31:0])) : WIDTH'(rs1_value_i[31:0]);
  assign b_ext = !word_in ? rs2_value_i :
                 is_signed_in ? WIDTH'(signed'(rs2_value_i[31:0])) : WIDTH'(rs2_value_i[31:0]);
  assign a_neg    = is_signed_in && a_ext[WIDTH-1];
  assign b_neg    = is_signed_in && b_ext[WIDTH-1];
  // most-negative magnitude wraps to itself, which is exactly the overflow quotient
  assign a_mag    = a_neg ? -a_ext : a_ext;
  assign b_mag    = b_neg ? -b_ext : b_ext;
  assign div0_in  = (b_ext == '0);
  assign cnt_load = word_in ? CW'(31) : CW'(WIDTH - 1);
  assign accept   = (state == IDLE) && valid_i && !flush_i;

`ifdef SEQ_DIV_FAST_PATH_EN
  logic             ovf_in;
  logic [WIDTH-1:0] min_val;
  assign min_val = word_in ? ({WIDTH{1'b1}} << 31) : (WIDTH'(1) << (WIDTH - 1));
  assign ovf_in  = is_signed_in && (a_ext == min_val) && (b_ext == {WIDTH{1'b1}});
  assign fast_in = div0_in || ovf_in;
`else
  assign fast_in = 1'b0;
`endif

  // one restoring step
  logic             msb;
  logic [WIDTH:0]   rem_sh, diff;
  assign msb    = word ? quo[31] : quo[WIDTH-1];
  assign rem_sh = {rem, msb};
  assign diff   = rem_sh - {1'b0, divisor};

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // next-state logic; flush overrides everything
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (valid_i) state_nxt = fast_in ? DONE : BUSY;
      BUSY: if (cnt == '0) state_nxt = DONE;
      DONE: if (ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  // datapath: capture on accept, iterate while BUSY
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      is_rem  <= 1'b0;
      word    <= 1'b0;
      rob_idx <= '0;
    end else if (accept) begin
      divisor <= b_mag;
      cnt     <= cnt_load;
      neg_q   <= a_neg ^ b_neg && !div0_in;
      neg_r   <= a_neg;
      is_rem  <= ctl_i[1];
      word    <= word_in;
      rob_idx <= rob_idx_i;
      if (fast_in && div0_in) begin
        quo <= {WIDTH{1'b1}};
        rem <= a_mag;
      end else begin
        quo <= a_mag;
        rem <= '0;
      end
    end else if (state == BUSY && !flush_i) begin
      cnt <= cnt - 1'b1;
      if (!diff[WIDTH]) begin
        rem <= diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= rem_sh[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // sign fix-up and word sign-extension of the final result
  logic [WIDTH-1:0] q_mag, q_val, r_val, sel;
  assign q_mag = word ? (quo & WIDTH'(32'hFFFF_FFFF)) : quo;
  assign q_val = neg_q ? -q_mag : q_mag;
  assign r_val = neg_r ? -rem : rem;
  assign sel   = is_rem ? r_val : q_val;

  assign result_o        = word ? WIDTH'(signed'(sel[31:0])) : sel;
  assign rob_idx_o       = rob_idx;
  assign ready_o         = (state == IDLE);
  assign valid_o         = (state == DONE);
  assign except_raised_o = 1'b0;
  assign except_code_o   = '0;

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div (WIDTH=64).
module tb_seq_div;

  logic                     clk_i = 1'b0;
  logic                     rst_ni = 1'b0;
  logic                     flush_i = 1'b0;
  logic                     valid_i = 1'b0;
  logic                     ready_o;
  logic                     valid_o;
  logic                     ready_i = 1'b0;
  logic [3:0]               ctl_i = '0;
  logic [63:0]              rs1_value_i = '0;
  logic [63:0]              rs2_value_i = '0;
  expipe_pkg::rob_idx_t     rob_idx_i = '0;
  expipe_pkg::rob_idx_t     rob_idx_o;
  logic [63:0]              result_o;
  logic                     except_raised_o;
  expipe_pkg::except_code_t except_code_o;

  int checks = 0;
  int errors = 0;

`ifdef SEQ_DIV_FAST_PATH_EN
  localparam int LAT_SPECIAL = 0;
`else
  localparam int LAT_SPECIAL = 64;
`endif

  seq_div #(.WIDTH(64), .EU_CTL_LEN(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .valid_o(valid_o), .ready_i(ready_i),
    .ctl_i(ctl_i), .rs1_value_i(rs1_value_i), .rs2_value_i(rs2_value_i),
    .rob_idx_i(rob_idx_i), .rob_idx_o(rob_idx_o), .result_o(result_o),
    .except_raised_o(except_raised_o), .except_code_o(except_code_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [3:0] ctl, input logic [63:0] a, input logic [63:0] b,
                          input logic [5:0] rob);
    ctl_i = ctl; rs1_value_i = a; rs2_value_i = b; rob_idx_i = rob; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic ack();
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    chk("ack_ready", {63'd0, ready_o}, 64'd1);
    chk("ack_valid", {63'd0, valid_o}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [3:0] ctl, input logic [63:0] a,
                        input logic [63:0] b, input logic [5:0] rob,
                        input logic [63:0] exp, input int lat, input bit do_ack);
    int n;
    start_op(ctl, a, b, rob);
    n = 0;
    while (valid_o !== 1'b1 && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_res"}, result_o, exp);
    chk({tag, "_rob"}, {58'd0, rob_idx_o}, {58'd0, rob});
    if (do_ack) ack();
  endtask

  initial begin
    int n;
    bit seen;
    #12;
    chk("rst_ready", {63'd0, ready_o}, 64'd1);
    chk("rst_valid", {63'd0, valid_o}, 64'd0);
    chk("rst_result", result_o, 64'd0);
    chk("rst_rob", {58'd0, rob_idx_o}, 64'd0);
    chk("rst_exc", {58'd0, except_raised_o, except_code_o}, 64'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    run_op("div_m7_2",  4'b0000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd3,
           64'hFFFF_FFFF_FFFF_FFFD, 64, 1'b1);
    chk("exc_raised", {63'd0, except_raised_o}, 64'd0);
    run_op("rem_m7_2",  4'b0010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd4,
           64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b1);
    run_op("divuw",     4'b0101, 64'hFFFF_FFFF_8000_0000, 64'd2, 6'd5,
           64'h0000_0000_4000_0000, 32, 1'b1);
    run_op("div_by0",   4'b0000, 64'd123, 64'd0, 6'd6,
           64'hFFFF_FFFF_FFFF_FFFF, LAT_SPECIAL, 1'b1);
    run_op("remu_by0",  4'b0011, 64'd5, 64'd0, 6'd7, 64'd5, LAT_SPECIAL, 1'b1);
    run_op("div_ovf",   4'b0000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd8,
           64'h8000_0000_0000_0000, LAT_SPECIAL, 1'b1);
    run_op("rem_ovf",   4'b0010, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd9,
           64'd0, LAT_SPECIAL, 1'b1);
    run_op("divu_big",  4'b0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 6'd10,
           64'h0FFF_FFFF_FFFF_FFFF, 64, 1'b1);
    run_op("div_negneg", 4'b0000, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 6'd11,
           64'd14, 64, 1'b1);
    run_op("divw",      4'b0100, 64'h1234_5678_FFFF_FFF0, 64'hABCD_0000_0000_0003, 6'd12,
           64'hFFFF_FFFF_FFFF_FFFB, 32, 1'b1);
    run_op("remw",      4'b0110, 64'h1234_5678_FFFF_FFF0, 64'd3, 6'd13,
           64'hFFFF_FFFF_FFFF_FFFF, 32, 1'b1);
    run_op("remu",      4'b0011, 64'd100, 64'd7, 6'd14, 64'd2, 64, 1'b1);

    // output stall: result and tag hold while ready_i is low
    run_op("divu_stall", 4'b0001, 64'd100, 64'd7, 6'd42, 64'd14, 64, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      chk("stall_valid", {63'd0, valid_o}, 64'd1);
      chk("stall_res", result_o, 64'd14);
      chk("stall_rob", {58'd0, rob_idx_o}, 64'd42);
    end
    ack();

    // flush in the middle of BUSY
    start_op(4'b0000, 64'd1000, 64'd3, 6'd20);
    repeat (19) @(posedge clk_i);
    #1;
    chk("flush_busy", {63'd0, ready_o}, 64'd0);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    chk("flush_ready", {63'd0, ready_o}, 64'd1);
    chk("flush_valid", {63'd0, valid_o}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk_i); #1;
      if (valid_o !== 1'b0) seen = 1'b1;
    end
    chk("flush_no_valid", {63'd0, seen}, 64'd0);

    // reset in the middle of BUSY
    start_op(4'b0001, 64'd77, 64'd5, 6'd33);
    repeat (10) @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("mrst_ready", {63'd0, ready_o}, 64'd1);
    chk("mrst_valid", {63'd0, valid_o}, 64'd0);
    chk("mrst_result", result_o, 64'd0);
    chk("mrst_rob", {58'd0, rob_idx_o}, 64'd0);
    chk("mrst_exc", {58'd0, except_raised_o, except_code_o}, 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    run_op("post_rst", 4'b0001, 64'd77, 64'd5, 6'd34, 64'd15, 64, 1'b1);

    n = checks;
    $display("CHECKS %0d ERRORS %0d", n, errors);
    $finish;
  end

endmodule
